// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared loader types and stream geometry
package cpu_pkg;
  localparam int WORD_W    = 32;
  localparam int BYTE_W    = 8;
  localparam int HDR_BYTES = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA,
    ST_WRITE,
    ST_DONE,
    ST_ERR
  } loader_state_e;
endpackage

// File: rtl/byte_word_packer.sv
// rtl/byte_word_packer.sv - big-endian 4-byte shift/assemble unit with byte counter
module byte_word_packer
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              push,
  input  logic [BYTE_W-1:0] in_byte,
  output logic [WORD_W-1:0] word,
  output logic              word_valid,
  output logic [1:0]        byte_cnt
);
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [1:0]        cnt_q, cnt_d;

  // word is the assembled value including the byte being pushed this cycle
  assign word       = {shift_q[WORD_W-BYTE_W-1:0], in_byte};
  assign word_valid = push && (cnt_q == 2'd3);
  assign byte_cnt   = cnt_q;

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (clear) begin
      shift_d = '0;
      cnt_d   = 2'd0;
    end else if (push) begin
      shift_d = word;
      cnt_d   = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      shift_q <= '0;
      cnt_q   <= 2'd0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - length-prefixed byte-stream loader for the instruction memory
module imem_loader
  import cpu_pkg::*;
#(
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  output logic              in_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [WORD_W-1:0] im_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);
  loader_state_e     state_q, state_d;
  logic [15:0]       n_q, n_d;
  logic [ADDR_W-1:0] wcnt_q, wcnt_d;
  logic              in_ready_q, in_ready_d;
  logic              im_we_q, im_we_d;
  logic [ADDR_W-1:0] im_addr_q, im_addr_d;
  logic [WORD_W-1:0] im_wdata_q, im_wdata_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              push, pk_clear, word_valid, last_word;
  logic [1:0]        byte_cnt;
  logic [WORD_W-1:0] word;

  assign push      = in_valid && in_ready_q;
  assign last_word = (16'(wcnt_q) == (n_q - 16'd1));

  byte_word_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (pk_clear),
    .push      (push),
    .in_byte   (in_data),
    .word      (word),
    .word_valid(word_valid),
    .byte_cnt  (byte_cnt)
  );

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    wcnt_d     = wcnt_q;
    im_wdata_d = im_wdata_q;
    pk_clear   = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d  = ST_HDR;
          wcnt_d   = '0;
          pk_clear = 1'b1;
        end
      end
      ST_HDR: begin
        // The packer is reused for the header, then cleared so data starts on a word boundary
        if (push && (byte_cnt == 2'(HDR_BYTES - 1))) begin
          pk_clear = 1'b1;
          n_d      = word[15:0];
          if (word[15:0] == 16'd0)           state_d = ST_DONE;
          else if (word[15:0] > 16'(DEPTH))  state_d = ST_ERR;
          else                               state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (word_valid) begin
          state_d    = ST_WRITE;
          im_wdata_d = word;
        end
      end
      ST_WRITE: begin
        if (last_word) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DATA;
          wcnt_d  = wcnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // All outputs are registered, so they are derived from the next state
    in_ready_d = (state_d == ST_HDR) || (state_d == ST_DATA);
    im_we_d    = (state_d == ST_WRITE);
    im_addr_d  = im_we_d ? wcnt_q : im_addr_q;
    cpu_hold_d = (state_d != ST_DONE);
    busy_d     = (state_d == ST_HDR) || (state_d == ST_DATA) || (state_d == ST_WRITE);
    done_d     = (state_d == ST_DONE) && (state_q != ST_DONE);
    err_d      = (state_d == ST_ERR);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      n_q        <= '0;
      wcnt_q     <= '0;
      in_ready_q <= 1'b0;
      im_we_q    <= 1'b0;
      im_addr_q  <= '0;
      im_wdata_q <= '0;
      cpu_hold_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      wcnt_q     <= wcnt_d;
      in_ready_q <= in_ready_d;
      im_we_q    <= im_we_d;
      im_addr_q  <= im_addr_d;
      im_wdata_q <= im_wdata_d;
      cpu_hold_q <= cpu_hold_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign in_ready = in_ready_q;
  assign im_we    = im_we_q;
  assign im_addr  = im_addr_q;
  assign im_wdata = im_wdata_q;
  assign cpu_hold = cpu_hold_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader
module tb_imem_loader;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        im_we;
  logic [6:0]  im_addr;
  logic [31:0] im_wdata;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        err;

  imem_loader #(.DEPTH(128), .ADDR_W(7)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .in_valid(in_valid),
    .in_data (in_data),
    .in_ready(in_ready),
    .im_we   (im_we),
    .im_addr (im_addr),
    .im_wdata(im_wdata),
    .cpu_hold(cpu_hold),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;

  int          n_chk  = 0;
  int          n_pass = 0;
  logic [7:0]  q[$];
  logic [6:0]  wr_addr[$];
  logic [31:0] wr_data[$];
  int          cyc = 0;
  int          done_cyc;
  int          start_edge;
  int          ready_bad;
  int          done_pulses;
  bit          done_seen;
  bit          rand_valid = 0;
  logic        prev_hold;
  logic        hold_at_done;
  logic        hold_before_done;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // One clock: present the head byte, pop it if it was accepted, log what the DUT did
  task automatic cycle();
    logic acc;
    in_valid = (q.size() > 0) && (!rand_valid || ($urandom_range(0, 1) == 1));
    in_data  = (q.size() > 0) ? q[0] : 8'h00;
    acc      = in_valid && in_ready;
    @(posedge clk);
    #1;
    cyc++;
    if (acc) void'(q.pop_front());
    if (im_we) begin
      wr_addr.push_back(im_addr);
      wr_data.push_back(im_wdata);
      if (in_ready) ready_bad++;
    end
    if (done) begin
      done_pulses++;
      if (!done_seen) begin
        done_seen        = 1;
        done_cyc         = cyc;
        hold_at_done     = cpu_hold;
        hold_before_done = prev_hold;
      end
    end
    prev_hold = cpu_hold;
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    done_seen   = 0;
    ready_bad   = 0;
    done_pulses = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
    start_edge = cyc;
  endtask

  task automatic push_hdr(input logic [15:0] n);
    q.push_back(n[15:8]);
    q.push_back(n[7:0]);
  endtask

  task automatic push_word(input logic [31:0] w);
    q.push_back(w[31:24]);
    q.push_back(w[23:16]);
    q.push_back(w[15:8]);
    q.push_back(w[7:0]);
  endtask

  task automatic run_until_done(input int budget, input string tag);
    int k = 0;
    while (!done_seen && k < budget) begin
      cycle();
      k++;
    end
    chk({tag, "_done_seen"}, 32'(done_seen), 32'd1);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_flags"}, {26'd0, in_ready, im_we, cpu_hold, busy, done, err}, 32'b001000);
    chk({tag, "_addr"}, 32'(im_addr), 32'd0);
    chk({tag, "_wdata"}, im_wdata, 32'd0);
  endtask

  initial begin
    int k;
    logic [31:0] words4[4];
    rst      = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    prev_hold = 1'b1;
    clear_log();
    cycle();
    cycle();
    chk_reset_state("reset");
    rst = 1'b1;
    cycle();

    // Two-word example program, in_valid held high
    clear_log();
    push_hdr(16'd2);
    push_word(32'h8C030000);
    push_word(32'h00000020);
    pulse_start();
    run_until_done(40, "t1");
    chk("t1_nwr", 32'(wr_addr.size()), 32'd2);
    if (wr_addr.size() == 2) begin
      chk("t1_addr0", 32'(wr_addr[0]), 32'd0);
      chk("t1_data0", wr_data[0], 32'h8C030000);
      chk("t1_addr1", 32'(wr_addr[1]), 32'd1);
      chk("t1_data1", wr_data[1], 32'h00000020);
    end
    chk("t1_latency", 32'(done_cyc - start_edge), 32'd12);
    chk("t1_hold_at_done", 32'(hold_at_done), 32'd0);
    chk("t1_hold_before", 32'(hold_before_done), 32'd1);
    cycle();
    chk("t1_done_one_shot", {30'd0, done, cpu_hold}, 32'b00);

    // 14 NOPs with a throttled source
    clear_log();
    rand_valid = 1;
    push_hdr(16'd14);
    for (int i = 0; i < 14; i++) push_word(32'h00000020);
    pulse_start();
    run_until_done(600, "t2");
    rand_valid = 0;
    chk("t2_nwr", 32'(wr_addr.size()), 32'd14);
    for (int i = 0; i < wr_addr.size(); i++) begin
      chk($sformatf("t2_addr%0d", i), 32'(wr_addr[i]), 32'(i));
      chk($sformatf("t2_data%0d", i), wr_data[i], 32'h00000020);
    end
    chk("t2_left_bytes", 32'(q.size()), 32'd0);
    chk("t2_ready_on_write", 32'(ready_bad), 32'd0);

    // Empty program and oversize header
    clear_log();
    push_hdr(16'd0);
    pulse_start();
    run_until_done(20, "t3a");
    chk("t3a_latency", 32'(done_cyc - start_edge), 32'd2);
    chk("t3a_nwr", 32'(wr_addr.size()), 32'd0);
    clear_log();
    push_hdr(16'h0081);
    pulse_start();
    for (int i = 0; i < 8; i++) cycle();
    chk("t3b_flags", {27'd0, err, cpu_hold, in_ready, busy, done}, 32'b11000);
    chk("t3b_nwr", 32'(wr_addr.size()), 32'd0);
    chk("t3b_done_pulses", 32'(done_pulses), 32'd0);
    clear_log();
    push_hdr(16'd0);
    pulse_start();
    chk("t3c_err_cleared", 32'(err), 32'd0);
    run_until_done(20, "t3c");

    // Reset in the middle of a 4-word load, then a fresh 1-word load
    clear_log();
    words4[0] = 32'h11223344;
    words4[1] = 32'h55667788;
    words4[2] = 32'h99AABBCC;
    words4[3] = 32'hDDEEFF00;
    push_hdr(16'd4);
    for (int i = 0; i < 4; i++) push_word(words4[i]);
    pulse_start();
    k = 0;
    while (wr_addr.size() < 2 && k < 100) begin
      cycle();
      k++;
    end
    chk("t4_two_written", 32'(wr_addr.size()), 32'd2);
    if (wr_addr.size() == 2) chk("t4_data1", wr_data[1], 32'h55667788);
    cycle();
    cycle();
    rst = 1'b0;
    cycle();
    chk_reset_state("t4_midreset");
    rst = 1'b1;
    q.delete();
    clear_log();
    push_hdr(16'd1);
    push_word(32'hDEADBEEF);
    pulse_start();
    run_until_done(30, "t4b");
    chk("t4b_nwr", 32'(wr_addr.size()), 32'd1);
    if (wr_addr.size() == 1) begin
      chk("t4b_addr", 32'(wr_addr[0]), 32'd0);
      chk("t4b_data", wr_data[0], 32'hDEADBEEF);
    end

    // start during DATA is ignored; start in DONE reloads from address 0
    clear_log();
    push_hdr(16'd2);
    push_word(32'hA1A2A3A4);
    push_word(32'hB1B2B3B4);
    pulse_start();
    k = start_edge;
    for (int i = 0; i < 4; i++) cycle();
    pulse_start();
    start_edge = k;
    run_until_done(40, "t5");
    chk("t5_latency", 32'(done_cyc - start_edge), 32'd12);
    chk("t5_nwr", 32'(wr_addr.size()), 32'd2);
    if (wr_addr.size() == 2) begin
      chk("t5_data0", wr_data[0], 32'hA1A2A3A4);
      chk("t5_data1", wr_data[1], 32'hB1B2B3B4);
    end
    clear_log();
    push_hdr(16'd1);
    push_word(32'hCAFEF00D);
    pulse_start();
    chk("t5b_hold_back", {30'd0, cpu_hold, busy}, 32'b11);
    run_until_done(30, "t5b");
    chk("t5b_nwr", 32'(wr_addr.size()), 32'd1);
    if (wr_addr.size() == 1) begin
      chk("t5b_addr", 32'(wr_addr[0]), 32'd0);
      chk("t5b_data", wr_data[0], 32'hCAFEF00D);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
